// File: rtl/addsub_pkg.sv
// Shared types and constants for the adder operand/result interface.
package addsub_pkg;

    localparam int WIDTH = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
    } operand_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } result_t;

endpackage

// File: rtl/addsub16_pipe_prefix_cell.sv
// Kogge-Stone group combine: (g_hi, p_hi) o (g_lo, p_lo).
module prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/addsub16_pipe.sv
// Two-stage flow-controlled add/subtract unit on a Kogge-Stone prefix adder.
// Define ADDSUB_SAT_EN to saturate the sum on signed overflow.
module addsub16_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH     = addsub_pkg::WIDTH,
    parameter int S1_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int LEVELS = clog2(WIDTH);

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Handshake: a beat moves on any cycle where valid && ready; a stage
    // advances when it is empty or its downstream stage advances.
    logic s1_v, s2_v;
    logic s1_adv, s2_adv;

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;

    logic [WIDTH-1:0] bx, p0, g0;
    logic             c0;

    // Carry-in is folded into bit 0 so group generates become real carries.
    always_comb begin
        bx = (in_sub == OP_SUB) ? ~in_b : in_b;
        c0 = in_cin ^ in_sub;
        p0 = in_a ^ bx;
        g0 = (in_a & bx) | {{(WIDTH-1){1'b0}}, p0[0] & c0};
    end

    wire [WIDTH-1:0] lvl_g [0:LEVELS];
    wire [WIDTH-1:0] lvl_p [0:LEVELS];

    assign lvl_g[0] = g0;
    assign lvl_p[0] = p0;

    logic [WIDTH-1:0] s1_g, s1_gp, s1_p;
    logic             s1_c0, s1_a_msb, s1_bx_msb;

    for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
        localparam int DIST = 1 << lv;
        wire [WIDTH-1:0] src_g;
        wire [WIDTH-1:0] src_p;

        if (lv == S1_LEVELS) begin : g_from_reg
            assign src_g = s1_g;
            assign src_p = s1_gp;
        end else begin : g_from_comb
            assign src_g = lvl_g[lv];
            assign src_p = lvl_p[lv];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_cell
                prefix_cell u_cell (
                    .g_hi  (src_g[i]),
                    .p_hi  (src_p[i]),
                    .g_lo  (src_g[i-DIST]),
                    .p_lo  (src_p[i-DIST]),
                    .g_out (lvl_g[lv+1][i]),
                    .p_out (lvl_p[lv+1][i])
                );
            end else begin : g_pass
                assign lvl_g[lv+1][i] = src_g[i];
                assign lvl_p[lv+1][i] = src_p[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_g      <= '0;
            s1_gp     <= '0;
            s1_p      <= '0;
            s1_c0     <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_bx_msb <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_g      <= lvl_g[S1_LEVELS];
                s1_gp     <= lvl_p[S1_LEVELS];
                s1_p      <= p0;
                s1_c0     <= c0;
                s1_a_msb  <= in_a[WIDTH-1];
                s1_bx_msb <= bx[WIDTH-1];
            end
        end
    end

    logic [WIDTH-1:0] carry, sum_d;
    logic             cout_d, ovf_d;

    always_comb begin
        carry  = {lvl_g[LEVELS][WIDTH-2:0], s1_c0};
        sum_d  = s1_p ^ carry;
        cout_d = lvl_g[LEVELS][WIDTH-1];
        ovf_d  = (s1_a_msb == s1_bx_msb) && (sum_d[WIDTH-1] != s1_a_msb);
        if (SAT_EN && ovf_d) begin
            sum_d = s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v     <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_sum  <= sum_d;
                out_cout <= cout_d;
                out_ovf  <= ovf_d;
                out_zero <= (sum_d == '0);
            end
        end
    end

endmodule
